// File: rtl/dual_port_ram_pkg.sv
// dual_port_ram_pkg: default geometry and word/address types for dual_port_ram.
// Shared by the RAM and any agent that talks to it.
package dual_port_ram_pkg;

    localparam int DEFAULT_ADDR_W = 10;
    localparam int DEFAULT_DATA_W = 18;

    typedef logic [DEFAULT_ADDR_W-1:0] addr_t;
    typedef logic [DEFAULT_DATA_W-1:0] word_t;

endpackage

// File: rtl/dual_port_ram.sv
// dual_port_ram: true dual-port synchronous RAM, write-first per port, A wins collisions.
// Define DUAL_PORT_RAM_COLLISION_DETECT_EN to add a registered `collision` output.
module dual_port_ram
    import dual_port_ram_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addrA,
    input  logic [ADDR_W-1:0] addrB,
    input  logic [DATA_W-1:0] dataA,
    input  logic [DATA_W-1:0] dataB,
    input  logic              weA,
    input  logic              weB,
    output logic [DATA_W-1:0] qA,
    output logic [DATA_W-1:0] qB
`ifdef DUAL_PORT_RAM_COLLISION_DETECT_EN
    ,
    output logic              collision
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              same_addr;

    assign same_addr = (addrA == addrB);

    // Port A is written last so it wins a same-address write-write collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (weB) mem[addrB] <= dataB;
            if (weA) mem[addrA] <= dataA;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            qA <= '0;
            qB <= '0;
        end else begin
            qA <= weA ? dataA : mem[addrA];
            if (weB)
                qB <= (weA && same_addr) ? dataA : dataB;
            else
                qB <= mem[addrB];
        end
    end

`ifdef DUAL_PORT_RAM_COLLISION_DETECT_EN
    always_ff @(posedge clk) begin
        if (rst)
            collision <= 1'b0;
        else
            collision <= same_addr && (weA || weB);
    end
`endif

endmodule

// File: tb/tb_dual_port_ram.sv
// tb_dual_port_ram: directed vector table plus randomized traffic against a memory model.
// Collision output is checked when DUAL_PORT_RAM_COLLISION_DETECT_EN is defined.
module tb_dual_port_ram;
    import dual_port_ram_pkg::*;

    logic  clk = 1'b0;
    logic  rst;
    addr_t addrA, addrB;
    word_t dataA, dataB;
    logic  weA, weB;
    word_t qA, qB;
`ifdef DUAL_PORT_RAM_COLLISION_DETECT_EN
    logic  collision;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dual_port_ram dut (
        .clk   (clk),
        .rst   (rst),
        .addrA (addrA),
        .addrB (addrB),
        .dataA (dataA),
        .dataB (dataB),
        .weA   (weA),
        .weB   (weB),
        .qA    (qA),
        .qB    (qB)
`ifdef DUAL_PORT_RAM_COLLISION_DETECT_EN
        ,
        .collision (collision)
`endif
    );

    typedef struct {
        logic  rst;
        addr_t addr_a;
        addr_t addr_b;
        word_t data_a;
        word_t data_b;
        logic  we_a;
        logic  we_b;
        bit    chk_a;
        bit    chk_b;
        word_t exp_a;
        word_t exp_b;
        logic  exp_c;
    } vec_t;

    // Reference model: plain array of words plus "ever written" flags.
    word_t m_mem [1024];
    bit    m_vld [1024];
    word_t m_qa, m_qb;
    bit    m_qa_ok, m_qb_ok;
    logic  m_col;

    function automatic vec_t mk(logic r, int aa, int ab, int da, int db,
                                logic wa, logic wb, bit ca, bit cb,
                                int ea, int eb, logic ec);
        vec_t v;
        v.rst = r;
        v.addr_a = addr_t'(aa);
        v.addr_b = addr_t'(ab);
        v.data_a = word_t'(da);
        v.data_b = word_t'(db);
        v.we_a = wa;
        v.we_b = wb;
        v.chk_a = ca;
        v.chk_b = cb;
        v.exp_a = word_t'(ea);
        v.exp_b = word_t'(eb);
        v.exp_c = ec;
        return v;
    endfunction

    task automatic check(string name, word_t act, word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %05h expected %05h", name, act, exp);
        end
    endtask

    task automatic check_bit(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Advance the model by one edge using the spec rules on the driven inputs.
    task automatic model_step();
        int ia, ib;
        ia = int'(addrA);
        ib = int'(addrB);
        m_col = 1'b0;
        if (rst) begin
            m_qa = '0; m_qa_ok = 1;
            m_qb = '0; m_qb_ok = 1;
            return;
        end
        m_col = (ia == ib) && (weA || weB);
        if (weA) begin
            m_qa = dataA; m_qa_ok = 1;
        end else begin
            m_qa = m_mem[ia]; m_qa_ok = m_vld[ia];
        end
        if (weB) begin
            m_qb = (weA && ia == ib) ? dataA : dataB;
            m_qb_ok = 1;
        end else begin
            m_qb = m_mem[ib]; m_qb_ok = m_vld[ib];
        end
        if (weB) begin
            m_mem[ib] = dataB; m_vld[ib] = 1;
        end
        if (weA) begin
            m_mem[ia] = dataA; m_vld[ia] = 1;
        end
    endtask

    task automatic drive(logic r, addr_t aa, addr_t ab, word_t da, word_t db,
                         logic wa, logic wb);
        @(negedge clk);
        rst = r;
        addrA = aa; addrB = ab;
        dataA = da; dataB = db;
        weA = wa; weB = wb;
        @(posedge clk);
        model_step();
        #1;
    endtask

    vec_t vecs [16];

    initial begin
        for (int i = 0; i < 1024; i++) m_vld[i] = 0;
        rst = 0; addrA = '0; addrB = '0; dataA = '0; dataB = '0;
        weA = 0; weB = 0;

        vecs[0]  = mk(0, 'h000, 'h001, 'h15555, 0, 1, 0, 1, 0, 'h15555, 0, 0);
        vecs[1]  = mk(1, 'h000, 'h000, 'h3FFFF, 'h3FFFF, 1, 1, 1, 1, 0, 0, 0);
        vecs[2]  = mk(0, 'h000, 'h000, 0, 0, 0, 0, 1, 1, 'h15555, 'h15555, 0);
        vecs[3]  = mk(0, 'h020, 'h080, 0, 'h0C9E5, 0, 1, 0, 1, 0, 'h0C9E5, 0);
        vecs[4]  = mk(0, 'h080, 'h080, 0, 0, 0, 0, 1, 1, 'h0C9E5, 'h0C9E5, 0);
        vecs[5]  = mk(0, 'h020, 'h08C, 'h2E995, 0, 1, 0, 1, 0, 'h2E995, 0, 0);
        vecs[6]  = mk(0, 'h0AC, 'h08C, 'h0A99D, 'h24DF1, 1, 1, 1, 1, 'h0A99D, 'h24DF1, 0);
        vecs[7]  = mk(0, 'h020, 'h0AC, 0, 0, 0, 0, 1, 1, 'h2E995, 'h0A99D, 0);
        vecs[8]  = mk(0, 'h08C, 'h155, 0, 'h11111, 0, 1, 1, 1, 'h24DF1, 'h11111, 0);
        vecs[9]  = mk(0, 'h155, 'h155, 'h22222, 0, 1, 0, 1, 1, 'h22222, 'h11111, 1);
        vecs[10] = mk(0, 'h000, 'h155, 0, 0, 0, 0, 1, 1, 'h15555, 'h22222, 0);
        vecs[11] = mk(0, 'h3FF, 'h3FF, 'h00001, 'h00002, 1, 1, 1, 1, 'h00001, 'h00001, 1);
        vecs[12] = mk(0, 'h3FF, 'h000, 0, 0, 0, 0, 1, 1, 'h00001, 'h15555, 0);
        vecs[13] = mk(0, 'h020, 'h3FF, 0, 0, 0, 0, 1, 1, 'h2E995, 'h00001, 0);
        vecs[14] = mk(1, 'h020, 'h020, 'h12345, 0, 1, 0, 1, 1, 0, 0, 0);
        vecs[15] = mk(0, 'h020, 'h3FF, 0, 0, 0, 0, 1, 1, 'h2E995, 'h00001, 0);

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].rst, vecs[i].addr_a, vecs[i].addr_b,
                  vecs[i].data_a, vecs[i].data_b, vecs[i].we_a, vecs[i].we_b);
            if (vecs[i].chk_a) check($sformatf("vec%0d_qA", i), qA, vecs[i].exp_a);
            if (vecs[i].chk_b) check($sformatf("vec%0d_qB", i), qB, vecs[i].exp_b);
`ifdef DUAL_PORT_RAM_COLLISION_DETECT_EN
            check_bit($sformatf("vec%0d_col", i), collision, vecs[i].exp_c);
`endif
        end

        // Randomized traffic on a small address window to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            addr_t aa, ab;
            aa = ($urandom_range(0, 1) == 1) ? addr_t'($urandom_range(0, 7))
                                             : addr_t'($urandom_range(1016, 1023));
            ab = ($urandom_range(0, 2) == 0) ? aa
                                             : addr_t'($urandom_range(0, 7));
            drive(($urandom_range(0, 31) == 0), aa, ab,
                  word_t'($urandom), word_t'($urandom),
                  logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));
            if (m_qa_ok) check($sformatf("rnd%0d_qA", n), qA, m_qa);
            if (m_qb_ok) check($sformatf("rnd%0d_qB", n), qB, m_qb);
`ifdef DUAL_PORT_RAM_COLLISION_DETECT_EN
            check_bit($sformatf("rnd%0d_col", n), collision, m_col);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
